dispatch_queue_unit: RTL and testbench
======================================

// Module: dispatch_queue_unit
// PURPOSE
//  Buffered, parametrised issue stage between the fetcher/decoder and the ROB, RS and LSB.
//  - Queues decoded instructions in a QDEPTH-entry FIFO.
//  - Resolves source operands from regfile, ROB and N_CDB broadcast channels.
//  - Issues one instruction per cycle under per-unit back-pressure (rob_full, rs_full, lsb_full).
//  - Bypasses the rename done by the previous cycle's issue, so back-to-back dependents get correct tags.
// PARAMETERS
//  XLEN    32  data/pc/imm width
//  ROB_W   4   ROB alias width; alias 0 = "no dependency" (renamed zero)
//  OP_W    6   optype width
//  QDEPTH  4   FIFO entries, power of 2, >=2
//  N_CDB   2   number of result broadcast channels; channel 0 has highest priority
// PORTS
//  clk clk_in  1  clock
//  rst  in  1  synchronous active-high reset
//  rdy  in  1  global enable; 0 = freeze
//  rollback  in  1  mispredict flush
//  in_valid in 1 / in_ready out 1  decoded-instruction push handshake
//  in_pc in XLEN; in_imm in XLEN; in_optype in OP_W  decoded fields
//  in_is_ls in 1; in_is_jump in 1; in_pred_jump in 1  decoded class and fetch prediction
//  in_rd/in_rs1/in_rs2  in  5  register indices
//  rs1_2reg/rs2_2reg  out  5  head sources to regfile (combinational)
//  Qi_from_rg/Qj_from_rg in ROB_W; Vi_from_rg/Vj_from_rg in XLEN  regfile lookup
//  rob_Qi_rdy/rob_Qj_rdy in 1; Vi_from_rob/Vj_from_rob in XLEN  ROB completed-value lookup
//  rob_alias  in  ROB_W  alias the ROB allocates to the head
//  rob_full/rs_full/lsb_full  in  1  back-pressure
//  cdb_valid in N_CDB; cdb_alias in N_CDB*ROB_W; cdb_data in N_CDB*XLEN  broadcasts
//  ena_rob out 1; rob_pc out XLEN; rob_rd out 5; rob_optype out OP_W; rob_is_jump out 1; rob_pred out 1
//  ena_rename out 1; rename_rd out 5; rename_alias out ROB_W
//  ena_rs out 1; ena_lsb out 1  target strobe
//  iss_alias out ROB_W; iss_optype out OP_W; iss_pc out XLEN; iss_imm out XLEN  shared payload
//  iss_Qi/iss_Qj out ROB_W; iss_Vi/iss_Vj out XLEN  shared payload operands
// BEHAVIOUR
//  - Reset or rollback (sync, rollback dominates rdy): wr_ptr=rd_ptr=count=0, all ena_* = 0, bypass record cleared.
//    Payload regs = 0 on reset and hold on rollback. Any push that cycle is dropped.
//  - rdy=0: pointers, count, bypass record and all outputs hold. in_ready is forced to 0.
//  - in_ready = rdy & (count != QDEPTH). A push is accepted when in_valid & in_ready.
//  - Push and pop may occur in the same cycle; count is unchanged.
//  - Pointers wrap mod QDEPTH.
//  - A pushed entry is visible at the head no earlier than the next cycle.
//  - Issue fires when count!=0 & ~rob_full & (head.is_ls ? ~lsb_full : ~rs_full).
//    Issue pops the head. Next edge: ena_rob=1, and exactly one of ena_lsb / ena_rs =1 (by is_ls).
//    Payload is latched and iss_alias = rob_alias.
//    No issue -> all ena_* = 0 the next cycle.
//    Latency: accept -> ena_* >= 2 cycles. Throughput: 1 per cycle.
//  - Rename: ena_rename=1 only if issued rd != 0; rename_rd=rd, rename_alias=rob_alias.
//    The ROB entry is still created when rd == 0.
//  - Operand resolution, per source, combinational on head (first match wins):
//    1. Bypass: previous cycle issued with rd!=0 and rd==rs -> Q=prev alias.
//       The tag from step 1 is then checked in step 4 only.
//    2. Source register x0 -> Q=0, V=0.
//    3. Otherwise take Q/V from the regfile; rob_Q*_rdy=1 overrides with Q=0, V=ROB value.
//    4. If Q!=0 and some cdb_valid[k] & cdb_alias[k]==Q -> Q=0, V=cdb_data[k], lowest k wins.
//  - The bypass record is updated on every issue, cleared on a non-issue cycle, reset and rollback.
// TESTING
//  1. Reset with in_valid=1 -> in_ready=0 during rst. All ena_*=0 and count=0 one cycle after rst drops.
//  2. Push 5 instructions with QDEPTH=4 and rs_full=1 -> in_ready falls after the 4th.
//     Drop rs_full -> 4 issues on consecutive cycles in FIFO order; the 5th is then accepted.
//  3. addi x5 (alias 3) then add x6,x5,x5 back-to-back -> second issue has iss_Qi=iss_Qj=3.
//     It must not use the stale regfile tag 0.
//  4. Head rs1 tag 7, cdb_valid=2'b11, both aliases 7, data 0xA / 0xB -> iss_Qi=0, iss_Vi=0xA.
//  5. lsb_full=1 with a load at the head and an ALU op behind it -> no issue and no overtaking.
//     Release -> load, then ALU op.
//  6. rollback asserted with 3 queued and a push -> next cycle count=0, no ena_*.
//     Instruction with rd=x0 -> ena_rob=1, ena_rename=0.

Source files
------------

// File: rtl/dispatch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_queue_unit
// Description : Buffered issue stage that resolves operands for the head of a
//               decoded-instruction FIFO and dispatches to ROB / RS / LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_queue_unit #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int QDEPTH = 4,
    parameter int N_CDB  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_imm,
    input  logic [OP_W-1:0]         in_optype,
    input  logic                    in_is_ls,
    input  logic                    in_is_jump,
    input  logic                    in_pred_jump,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    output logic [4:0]              rs1_2reg,
    output logic [4:0]              rs2_2reg,
    input  logic [ROB_W-1:0]        Qi_from_rg,
    input  logic [ROB_W-1:0]        Qj_from_rg,
    input  logic [XLEN-1:0]         Vi_from_rg,
    input  logic [XLEN-1:0]         Vj_from_rg,
    input  logic                    rob_Qi_rdy,
    input  logic                    rob_Qj_rdy,
    input  logic [XLEN-1:0]         Vi_from_rob,
    input  logic [XLEN-1:0]         Vj_from_rob,
    input  logic [ROB_W-1:0]        rob_alias,
    input  logic                    rob_full,
    input  logic                    rs_full,
    input  logic                    lsb_full,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*ROB_W-1:0]  cdb_alias,
    input  logic [N_CDB*XLEN-1:0]   cdb_data,
    output logic                    ena_rob,
    output logic [XLEN-1:0]         rob_pc,
    output logic [4:0]              rob_rd,
    output logic [OP_W-1:0]         rob_optype,
    output logic                    rob_is_jump,
    output logic                    rob_pred,
    output logic                    ena_rename,
    output logic [4:0]              rename_rd,
    output logic [ROB_W-1:0]        rename_alias,
    output logic                    ena_rs,
    output logic                    ena_lsb,
    output logic [ROB_W-1:0]        iss_alias,
    output logic [OP_W-1:0]         iss_optype,
    output logic [XLEN-1:0]         iss_pc,
    output logic [XLEN-1:0]         iss_imm,
    output logic [ROB_W-1:0]        iss_Qi,
    output logic [ROB_W-1:0]        iss_Qj,
    output logic [XLEN-1:0]         iss_Vi,
    output logic [XLEN-1:0]         iss_Vj
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(QDEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [OP_W-1:0] optype;
        logic            is_ls;
        logic            is_jump;
        logic            pred;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } entry_t;

    entry_t             r_fifo [QDEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               r_byp_valid;
    logic [4:0]         r_byp_rd;
    logic [ROB_W-1:0]   r_byp_alias;

    logic               r_ena_rob;
    logic               r_ena_rs;
    logic               r_ena_lsb;
    logic               r_ena_rename;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_imm;
    logic [OP_W-1:0]    r_optype;
    logic [4:0]         r_rd;
    logic               r_is_jump;
    logic               r_pred;
    logic [ROB_W-1:0]   r_alias;
    logic [ROB_W-1:0]   r_qi;
    logic [ROB_W-1:0]   r_qj;
    logic [XLEN-1:0]    r_vi;
    logic [XLEN-1:0]    r_vj;

    entry_t             w_head;
    entry_t             w_in_entry;
    logic               w_push;
    logic               w_issue;
    logic               w_target_free;

    logic [4:0]         w_src     [2];
    logic [ROB_W-1:0]   w_rg_q    [2];
    logic [XLEN-1:0]    w_rg_v    [2];
    logic               w_rob_rdy [2];
    logic [XLEN-1:0]    w_rob_v   [2];
    logic [ROB_W-1:0]   w_base_q  [2];
    logic [XLEN-1:0]    w_base_v  [2];
    logic [ROB_W-1:0]   w_opq     [2];
    logic [XLEN-1:0]    w_opv     [2];

    assign w_head     = r_fifo[r_rd_ptr];
    assign w_in_entry = '{pc: in_pc, imm: in_imm, optype: in_optype, is_ls: in_is_ls,
                          is_jump: in_is_jump, pred: in_pred_jump, rd: in_rd,
                          rs1: in_rs1, rs2: in_rs2};

    // Handshake is gated by rst/rollback as well so a dropped push is never acknowledged
    assign in_ready      = rdy & ~rst & ~rollback & (r_count != c_depth);
    assign w_push        = in_valid & in_ready;
    assign w_target_free = w_head.is_ls ? ~lsb_full : ~rs_full;
    assign w_issue       = rdy & ~rst & ~rollback & (r_count != '0) & ~rob_full & w_target_free;

    assign rs1_2reg = w_head.rs1;
    assign rs2_2reg = w_head.rs2;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand resolution for both head sources; the CDB loop runs high-to-low so channel 0 wins
    always_comb begin
        w_src[0]     = w_head.rs1;
        w_src[1]     = w_head.rs2;
        w_rg_q[0]    = Qi_from_rg;
        w_rg_q[1]    = Qj_from_rg;
        w_rg_v[0]    = Vi_from_rg;
        w_rg_v[1]    = Vj_from_rg;
        w_rob_rdy[0] = rob_Qi_rdy;
        w_rob_rdy[1] = rob_Qj_rdy;
        w_rob_v[0]   = Vi_from_rob;
        w_rob_v[1]   = Vj_from_rob;
        for (int s = 0; s < 2; s++) begin
            w_base_q[s] = '0;
            w_base_v[s] = '0;
            if (r_byp_valid && (r_byp_rd == w_src[s])) begin
                w_base_q[s] = r_byp_alias;
            end else if (w_src[s] != 5'd0) begin
                if (w_rob_rdy[s]) begin
                    w_base_v[s] = w_rob_v[s];
                end else begin
                    w_base_q[s] = w_rg_q[s];
                    w_base_v[s] = w_rg_v[s];
                end
            end
            w_opq[s] = w_base_q[s];
            w_opv[s] = w_base_v[s];
            for (int k = N_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && (w_base_q[s] != '0) &&
                    (cdb_alias[k*ROB_W +: ROB_W] == w_base_q[s])) begin
                    w_opq[s] = '0;
                    w_opv[s] = cdb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena_rob    <= 1'b0;
            r_ena_rs     <= 1'b0;
            r_ena_lsb    <= 1'b0;
            r_ena_rename <= 1'b0;
            r_byp_valid  <= 1'b0;
            r_byp_rd     <= '0;
            r_byp_alias  <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_optype     <= '0;
            r_rd         <= '0;
            r_is_jump    <= 1'b0;
            r_pred       <= 1'b0;
            r_alias      <= '0;
            r_qi         <= '0;
            r_qj         <= '0;
            r_vi         <= '0;
            r_vj         <= '0;
        end else if (rollback) begin
            r_ena_rob    <= 1'b0;
            r_ena_rs     <= 1'b0;
            r_ena_lsb    <= 1'b0;
            r_ena_rename <= 1'b0;
            r_byp_valid  <= 1'b0;
        end else if (rdy) begin
            r_ena_rob    <= w_issue;
            r_ena_rs     <= w_issue & ~w_head.is_ls;
            r_ena_lsb    <= w_issue & w_head.is_ls;
            r_ena_rename <= w_issue & (w_head.rd != 5'd0);
            r_byp_valid  <= w_issue & (w_head.rd != 5'd0);
            if (w_issue) begin
                r_byp_rd    <= w_head.rd;
                r_byp_alias <= rob_alias;
                r_pc        <= w_head.pc;
                r_imm       <= w_head.imm;
                r_optype    <= w_head.optype;
                r_rd        <= w_head.rd;
                r_is_jump   <= w_head.is_jump;
                r_pred      <= w_head.pred;
                r_alias     <= rob_alias;
                r_qi        <= w_opq[0];
                r_qj        <= w_opq[1];
                r_vi        <= w_opv[0];
                r_vj        <= w_opv[1];
            end
        end
    end

    assign ena_rob      = r_ena_rob;
    assign ena_rs       = r_ena_rs;
    assign ena_lsb      = r_ena_lsb;
    assign ena_rename   = r_ena_rename;
    assign rob_pc       = r_pc;
    assign rob_rd       = r_rd;
    assign rob_optype   = r_optype;
    assign rob_is_jump  = r_is_jump;
    assign rob_pred     = r_pred;
    assign rename_rd    = r_rd;
    assign rename_alias = r_alias;
    assign iss_alias    = r_alias;
    assign iss_optype   = r_optype;
    assign iss_pc       = r_pc;
    assign iss_imm      = r_imm;
    assign iss_Qi       = r_qi;
    assign iss_Qj       = r_qj;
    assign iss_Vi       = r_vi;
    assign iss_Vj       = r_vj;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_queue_unit
// Description : Self-checking bench: directed corner cases, an operand table
//               and a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue_unit;

    localparam int XLEN   = 32;
    localparam int ROB_W  = 4;
    localparam int OP_W   = 6;
    localparam int QDEPTH = 4;
    localparam int N_CDB  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, rollback, in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_imm;
    logic [OP_W-1:0] in_optype;
    logic in_is_ls, in_is_jump, in_pred_jump;
    logic [4:0] in_rd, in_rs1, in_rs2, rs1_2reg, rs2_2reg;
    logic [ROB_W-1:0] Qi_from_rg, Qj_from_rg;
    logic [XLEN-1:0] Vi_from_rg, Vj_from_rg, Vi_from_rob, Vj_from_rob;
    logic rob_Qi_rdy, rob_Qj_rdy;
    logic [ROB_W-1:0] rob_alias;
    logic rob_full, rs_full, lsb_full;
    logic [N_CDB-1:0] cdb_valid;
    logic [N_CDB*ROB_W-1:0] cdb_alias;
    logic [N_CDB*XLEN-1:0] cdb_data;
    logic ena_rob, rob_is_jump, rob_pred, ena_rename, ena_rs, ena_lsb;
    logic [XLEN-1:0] rob_pc, iss_pc, iss_imm, iss_Vi, iss_Vj;
    logic [4:0] rob_rd, rename_rd;
    logic [OP_W-1:0] rob_optype, iss_optype;
    logic [ROB_W-1:0] rename_alias, iss_alias, iss_Qi, iss_Qj;

    dispatch_queue_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .QDEPTH(QDEPTH), .N_CDB(N_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_optype(in_optype),
        .in_is_ls(in_is_ls), .in_is_jump(in_is_jump), .in_pred_jump(in_pred_jump),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .rs1_2reg(rs1_2reg), .rs2_2reg(rs2_2reg),
        .Qi_from_rg(Qi_from_rg), .Qj_from_rg(Qj_from_rg),
        .Vi_from_rg(Vi_from_rg), .Vj_from_rg(Vj_from_rg),
        .rob_Qi_rdy(rob_Qi_rdy), .rob_Qj_rdy(rob_Qj_rdy),
        .Vi_from_rob(Vi_from_rob), .Vj_from_rob(Vj_from_rob),
        .rob_alias(rob_alias), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_data(cdb_data),
        .ena_rob(ena_rob), .rob_pc(rob_pc), .rob_rd(rob_rd), .rob_optype(rob_optype),
        .rob_is_jump(rob_is_jump), .rob_pred(rob_pred),
        .ena_rename(ena_rename), .rename_rd(rename_rd), .rename_alias(rename_alias),
        .ena_rs(ena_rs), .ena_lsb(ena_lsb),
        .iss_alias(iss_alias), .iss_optype(iss_optype), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_Qi(iss_Qi), .iss_Qj(iss_Qj), .iss_Vi(iss_Vi), .iss_Vj(iss_Vj)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0] pc, imm;
        logic [OP_W-1:0] op;
        logic is_ls, is_jump, pred;
        logic [4:0] rd, rs1, rs2;
    } instr_t;

    instr_t mq[$];
    bit m_armed = 1'b0;
    logic m_last_valid;
    logic [4:0] m_last_rd;
    logic [ROB_W-1:0] m_last_alias;
    logic e_ena_rob, e_ena_rs, e_ena_lsb, e_ena_ren, e_isj, e_pred;
    logic [XLEN-1:0] e_pc, e_imm, e_vi, e_vj;
    logic [OP_W-1:0] e_op;
    logic [4:0] e_rd;
    logic [ROB_W-1:0] e_alias, e_qi, e_qj;

    // Tag/value a source ends up with when it is dispatched this cycle
    task automatic resolve(input logic [4:0] rs, input logic [ROB_W-1:0] qrg, input logic [XLEN-1:0] vrg,
                           input logic rrdy, input logic [XLEN-1:0] vrob,
                           output logic [ROB_W-1:0] q, output logic [XLEN-1:0] v);
        if (m_last_valid && m_last_rd == rs) begin q = m_last_alias; v = '0; end
        else if (rs == 5'd0)                 begin q = '0; v = '0; end
        else if (rrdy)                       begin q = '0; v = vrob; end
        else                                 begin q = qrg; v = vrg; end
        if (q != '0) begin
            for (int k = 0; k < N_CDB; k++) begin
                if (cdb_valid[k] && cdb_alias[k*ROB_W +: ROB_W] == q) begin
                    v = cdb_data[k*XLEN +: XLEN];
                    q = '0;
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        instr_t h, n;
        bit acc, iss;
        if (rst) begin
            mq.delete();
            {e_ena_rob, e_ena_rs, e_ena_lsb, e_ena_ren} = '0;
            {e_pc, e_imm, e_op, e_rd, e_isj, e_pred, e_alias, e_qi, e_qj, e_vi, e_vj} = '0;
            m_last_valid = 1'b0;
            m_armed = 1'b1;
        end else if (rollback) begin
            mq.delete();
            {e_ena_rob, e_ena_rs, e_ena_lsb, e_ena_ren} = '0;
            m_last_valid = 1'b0;
        end else if (rdy) begin
            acc = in_valid && (mq.size() < QDEPTH);
            iss = (mq.size() != 0) && !rob_full && (mq[0].is_ls ? !lsb_full : !rs_full);
            if (iss) begin
                h = mq.pop_front();
                e_ena_rob = 1'b1; e_ena_rs = !h.is_ls; e_ena_lsb = h.is_ls; e_ena_ren = (h.rd != 0);
                e_pc = h.pc; e_imm = h.imm; e_op = h.op; e_rd = h.rd;
                e_isj = h.is_jump; e_pred = h.pred; e_alias = rob_alias;
                resolve(h.rs1, Qi_from_rg, Vi_from_rg, rob_Qi_rdy, Vi_from_rob, e_qi, e_vi);
                resolve(h.rs2, Qj_from_rg, Vj_from_rg, rob_Qj_rdy, Vj_from_rob, e_qj, e_vj);
                m_last_valid = (h.rd != 0); m_last_rd = h.rd; m_last_alias = rob_alias;
            end else begin
                {e_ena_rob, e_ena_rs, e_ena_lsb, e_ena_ren} = '0;
                m_last_valid = 1'b0;
            end
            if (acc) begin
                n = '{pc: in_pc, imm: in_imm, op: in_optype, is_ls: in_is_ls, is_jump: in_is_jump,
                      pred: in_pred_jump, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
                mq.push_back(n);
            end
        end
    endtask

    logic [203:0] cmp_act, cmp_exp;
    logic [XLEN-1:0] a_vi, a_vj, x_vi, x_vj;

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_armed) begin
            a_vi = (e_qi == '0) ? iss_Vi : '0;
            a_vj = (e_qj == '0) ? iss_Vj : '0;
            x_vi = (e_qi == '0) ? e_vi : '0;
            x_vj = (e_qj == '0) ? e_vj : '0;
            cmp_act = {ena_rob, ena_rs, ena_lsb, ena_rename, rob_pc, iss_pc, rob_rd, rename_rd,
                       rob_optype, iss_optype, rob_is_jump, rob_pred, rename_alias, iss_alias,
                       iss_imm, iss_Qi, iss_Qj, a_vi, a_vj};
            cmp_exp = {e_ena_rob, e_ena_rs, e_ena_lsb, e_ena_ren, e_pc, e_pc, e_rd, e_rd,
                       e_op, e_op, e_isj, e_pred, e_alias, e_alias,
                       e_imm, e_qi, e_qj, x_vi, x_vj};
            check("cycle_outputs", 256'(cmp_act), 256'(cmp_exp));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_instr(input logic [XLEN-1:0] pc, input logic ls, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        in_pc = pc; in_imm = pc + 32'h1000; in_optype = pc[OP_W-1:0];
        in_is_ls = ls; in_is_jump = 1'b0; in_pred_jump = 1'b0;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    task automatic push(input logic [XLEN-1:0] pc, input logic ls, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge clk);
        set_instr(pc, ls, rd, rs1, rs2);
        in_valid = 1'b1;
        #1 check("push_ready", 256'(in_ready), 256'(1'b1));
    endtask

    task automatic quiet_operands();
        Qi_from_rg = '0; Qj_from_rg = '0; Vi_from_rg = '0; Vj_from_rg = '0;
        rob_Qi_rdy = 1'b0; rob_Qj_rdy = 1'b0; Vi_from_rob = '0; Vj_from_rob = '0;
        cdb_valid = '0; cdb_alias = '0; cdb_data = {32'hB, 32'hA};
    endtask

    typedef struct {
        logic [4:0]       rs1;
        logic [ROB_W-1:0] qrg;
        logic [XLEN-1:0]  vrg;
        logic             rrdy;
        logic [XLEN-1:0]  vrob;
        logic [1:0]       cv;
        logic [ROB_W-1:0] a0, a1;
        logic [ROB_W-1:0] exp_q;
        logic [XLEN-1:0]  exp_v;
    } vec_t;

    vec_t vt [7];
    bit accepted;

    initial begin
        vt[0] = '{5'd3, 4'd7, 32'h0,    1'b0, 32'h0,  2'b11, 4'd7, 4'd7, 4'd0, 32'hA};
        vt[1] = '{5'd3, 4'd7, 32'h0,    1'b0, 32'h0,  2'b10, 4'd7, 4'd7, 4'd0, 32'hB};
        vt[2] = '{5'd3, 4'd7, 32'h0,    1'b0, 32'h0,  2'b11, 4'd5, 4'd6, 4'd7, 32'h0};
        vt[3] = '{5'd3, 4'd0, 32'h1234, 1'b0, 32'h0,  2'b00, 4'd0, 4'd0, 4'd0, 32'h1234};
        vt[4] = '{5'd3, 4'd7, 32'h99,   1'b1, 32'h55, 2'b00, 4'd0, 4'd0, 4'd0, 32'h55};
        vt[5] = '{5'd0, 4'd7, 32'h9,    1'b0, 32'h0,  2'b11, 4'd7, 4'd7, 4'd0, 32'h0};
        vt[6] = '{5'd3, 4'd7, 32'h0,    1'b0, 32'h0,  2'b00, 4'd7, 4'd7, 4'd7, 32'h0};

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b1;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_alias = 4'd1;
        set_instr(32'd10, 1'b0, 5'd1, 5'd0, 5'd0);
        quiet_operands();

        // Reset with a push pending
        @(posedge clk); #1 check("reset_payload", 256'(iss_pc), 256'(0));
        @(negedge clk); #1 check("reset_in_ready", 256'(in_ready), 256'(1'b0));
        @(negedge clk); rst = 1'b0;
        #1 check("post_reset_ready", 256'(in_ready), 256'(1'b1));
        @(posedge clk); #1 check("post_reset_ena", 256'({ena_rob, ena_rs, ena_lsb, ena_rename}), 256'(4'b0));
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1 check("first_issue", 256'({ena_rob, ena_rs, ena_lsb, iss_pc}), 256'({3'b110, 32'd10}));

        // Fill to capacity under rs back-pressure, then drain in order
        @(negedge clk); rs_full = 1'b1;
        for (int i = 0; i < 4; i++) push(32'd100 + 32'(i), 1'b0, 5'd1, 5'd0, 5'd0);
        @(negedge clk);
        set_instr(32'd104, 1'b0, 5'd1, 5'd0, 5'd0);
        in_valid = 1'b1; rs_full = 1'b0;
        #1 check("full_in_ready", 256'(in_ready), 256'(1'b0));
        accepted = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 check("fifo_order", 256'({ena_rs, iss_pc}), 256'({1'b1, 32'd100 + 32'(k)}));
            @(negedge clk);
            if (accepted) in_valid = 1'b0;
            #1 if (in_valid && in_ready) accepted = 1'b1;
        end
        in_valid = 1'b0;

        // Back-to-back dependent: add x6,x5,x5 after addi x5
        push(32'd400, 1'b0, 5'd5, 5'd0, 5'd0); rob_alias = 4'd3;
        push(32'd401, 1'b0, 5'd6, 5'd5, 5'd5); rob_alias = 4'd3;
        @(posedge clk); #1 check("rename_first", 256'({ena_rename, rename_rd, rename_alias}), 256'({1'b1, 5'd5, 4'd3}));
        @(negedge clk); in_valid = 1'b0; rob_alias = 4'd4;
        @(posedge clk); #1 check("bypass_tags", 256'({iss_Qi, iss_Qj, iss_alias}), 256'({4'd3, 4'd3, 4'd4}));

        // Operand-resolution table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); in_valid = 1'b0; quiet_operands();
            push(32'd300 + 32'(i), 1'b0, 5'd1, vt[i].rs1, 5'd0);
            @(negedge clk);
            in_valid = 1'b0;
            Qi_from_rg = vt[i].qrg; Vi_from_rg = vt[i].vrg;
            rob_Qi_rdy = vt[i].rrdy; Vi_from_rob = vt[i].vrob;
            cdb_valid = vt[i].cv; cdb_alias = {vt[i].a1, vt[i].a0};
            @(posedge clk); #1
            check("opnd_q", 256'({ena_rs, iss_Qi}), 256'({1'b1, vt[i].exp_q}));
            if (vt[i].exp_q == '0) check("opnd_v", 256'(iss_Vi), 256'(vt[i].exp_v));
        end
        @(negedge clk); quiet_operands();

        // Load blocked by lsb_full must not be overtaken
        lsb_full = 1'b1;
        push(32'd200, 1'b1, 5'd2, 5'd0, 5'd0);
        push(32'd201, 1'b0, 5'd3, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in_valid = 1'b0;
            @(posedge clk); #1 check("lsb_block", 256'({ena_rob, ena_rs, ena_lsb}), 256'(3'b000));
        end
        @(negedge clk); lsb_full = 1'b0;
        @(posedge clk); #1 check("lsb_release_load", 256'({ena_lsb, ena_rs, iss_pc}), 256'({2'b10, 32'd200}));
        @(posedge clk); #1 check("lsb_release_alu", 256'({ena_lsb, ena_rs, iss_pc}), 256'({2'b01, 32'd201}));

        // Rollback with entries queued and a push in flight
        @(negedge clk); rs_full = 1'b1;
        for (int i = 0; i < 3; i++) push(32'd500 + 32'(i), 1'b0, 5'd1, 5'd0, 5'd0);
        @(negedge clk);
        set_instr(32'd503, 1'b0, 5'd1, 5'd0, 5'd0);
        in_valid = 1'b1; rollback = 1'b1; rs_full = 1'b0;
        @(posedge clk); #1 check("rollback_no_issue", 256'({ena_rob, ena_rs, ena_lsb}), 256'(3'b000));
        @(negedge clk); rollback = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1 check("rollback_flushed", 256'({ena_rob, ena_rs, ena_lsb}), 256'(3'b000));

        // rd = x0 still creates a ROB entry but no rename
        push(32'd600, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1 check("rd_x0", 256'({ena_rob, ena_rename}), 256'(2'b10));

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 199) == 0);
            rollback     = ($urandom_range(0, 49) == 0);
            rdy          = ($urandom_range(0, 9) != 0);
            in_valid     = ($urandom_range(0, 2) != 0);
            in_pc        = $urandom;
            in_imm       = $urandom;
            in_optype    = OP_W'($urandom_range(0, 63));
            in_is_ls     = ($urandom_range(0, 2) == 0);
            in_is_jump   = ($urandom_range(0, 1) == 0);
            in_pred_jump = ($urandom_range(0, 1) == 0);
            in_rd        = 5'($urandom_range(0, 3));
            in_rs1       = 5'($urandom_range(0, 3));
            in_rs2       = 5'($urandom_range(0, 3));
            rob_full     = ($urandom_range(0, 5) == 0);
            rs_full      = ($urandom_range(0, 3) == 0);
            lsb_full     = ($urandom_range(0, 3) == 0);
            Qi_from_rg   = ROB_W'($urandom_range(0, 3));
            Qj_from_rg   = ROB_W'($urandom_range(0, 3));
            Vi_from_rg   = $urandom;
            Vj_from_rg   = $urandom;
            rob_Qi_rdy   = ($urandom_range(0, 3) == 0);
            rob_Qj_rdy   = ($urandom_range(0, 3) == 0);
            Vi_from_rob  = $urandom;
            Vj_from_rob  = $urandom;
            rob_alias    = ROB_W'($urandom_range(1, 3));
            cdb_valid    = N_CDB'($urandom_range(0, 3));
            cdb_alias    = {ROB_W'($urandom_range(0, 3)), ROB_W'($urandom_range(0, 3))};
            cdb_data     = {$urandom, $urandom};
            #1;
            check("rand_in_ready", 256'(in_ready),
                  256'(rdy && !rst && !rollback && (mq.size() < QDEPTH)));
            if (mq.size() != 0)
                check("rand_src_regs", 256'({rs1_2reg, rs2_2reg}), 256'({mq[0].rs1, mq[0].rs2}));
        end

        @(negedge clk);
        rst = 1'b0; rollback = 1'b0; rdy = 1'b1; in_valid = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        quiet_operands();
        repeat (8) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
